// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
// Contents: aluop codes, R-type funct codes, the 4-bit internal op encoding
// produced by alu_op_decode, and the FSM state encoding of alu_seq_unit.
package alu_pkg;

  // aluop field: 00 add, 01 sub, 1x defer to funct
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  // Internal operation encoding (all 16 codes used)
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLL,
    OP_SRL, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational operation decoder.
// Ports:
//   aluop   [1:0]  in   00 add, 01 sub, 1x decode funct
//   funct   [5:0]  in   R-type function code
//   op      op_e   out  internal op code
//   multi          out  op needs the iterative multiply/divide sequencer
//   illegal        out  funct not in the supported set
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output op_e        op,
  output logic       multi,
  output logic       illegal
);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    if (aluop == ALUOP_ADD) begin
      op = OP_ADD;
    end else if (aluop == ALUOP_SUB) begin
      op = OP_SUB;
    end else begin
      case (funct)
        F_ADD:   op = OP_ADD;
        F_SUB:   op = OP_SUB;
        F_AND:   op = OP_AND;
        F_OR:    op = OP_OR;
        F_XOR:   op = OP_XOR;
        F_NOR:   op = OP_NOR;
        F_SLT:   op = OP_SLT;
        F_SLL:   op = OP_SLL;
        F_SRL:   op = OP_SRL;
        F_MFHI:  op = OP_MFHI;
        F_MFLO:  op = OP_MFLO;
        F_MULT:  op = OP_MULT;
        F_MULTU: op = OP_MULTU;
        F_DIV:   op = OP_DIV;
        F_DIVU:  op = OP_DIVU;
        default: begin
          op      = OP_ILL;
          illegal = 1'b1;
        end
      endcase
    end
    multi = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: MIPS-style ALU with single-cycle ops and an iterative
// shift-add multiplier / restoring divider sharing one datapath.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 request strobe, taken only while ready=1
//   aluop, funct, shamt   operation select; sll/srl shift operand b (rt)
//   a, b                  operands (rs, rt/imm)
//   ready                 idle and able to accept start
//   done, illegal         one-cycle completion / undefined-funct pulses
//   result, zero          registered result and result==0 flag
//   hi, lo                HI/LO registers written by mult/div
// Single-cycle ops complete one cycle after acceptance. mult/div spend
// WIDTH cycles iterating on operand magnitudes plus one FIX cycle for sign
// correction, so done arrives WIDTH+2 cycles after start.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  // Magnitude of x when treated as signed (sgn=1), else x unchanged
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  op_e  dec_op;
  logic dec_multi;
  logic dec_illegal;

  alu_op_decode u_dec (
    .aluop   (aluop),
    .funct   (funct),
    .op      (dec_op),
    .multi   (dec_multi),
    .illegal (dec_illegal)
  );

  state_e           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] acc_q,     acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] quo_q,     quo_d;     // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] dvs_q,     dvs_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_q,       a_d;       // raw dividend for the divide-by-zero result
  logic             is_div_q,  is_div_d;
  logic             neg_q,     neg_d;     // negate product / quotient
  logic             rneg_q,    rneg_d;    // negate remainder (dividend negative)
  logic             div0_q,    div0_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             done_q,    done_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;

  logic [WIDTH-1:0]   single_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic               op_signed;

  always_comb begin
    single_res = '0;
    case (dec_op)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_NOR:  single_res = ~(a | b);
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  single_res = b << shamt;
      OP_SRL:  single_res = b >> shamt;
      OP_MFHI: single_res = hi_q;
      OP_MFLO: single_res = lo_q;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    op_signed = (dec_op == OP_MULT) || (dec_op == OP_DIV);
    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the {acc,quo} pair right by one with the carry entering acc.
    mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    div_sh    = {acc_q, quo_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, dvs_q};
    prod      = {acc_q, quo_q};
    prod_fix  = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    result_d  = result_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dec_multi) begin
            is_div_d = (dec_op == OP_DIV) || (dec_op == OP_DIVU);
            acc_d    = '0;
            quo_d    = mag(a, op_signed);
            dvs_d    = mag(b, op_signed);
            a_d      = a;
            neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d   = op_signed && a[WIDTH-1];
            div0_d   = (b == '0);
            cnt_d    = CW'(WIDTH - 1);
            state_d  = ((dec_op == OP_DIV) || (dec_op == OP_DIVU)) ? ST_DIV : ST_MUL;
          end else begin
            result_d  = single_res;
            zero_d    = (single_res == '0);
            done_d    = 1'b1;
            illegal_d = dec_illegal;
          end
        end
      end

      ST_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_DIV: begin
        if (!div_diff[WIDTH]) begin
          acc_d = div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rneg_q ? -acc_q : acc_q;
          lo_d = neg_q  ? -quo_q : quo_q;
        end
        result_d = lo_d;
        zero_d   = (lo_d == '0);
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      div0_q    <= div0_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign done    = done_q;
  assign illegal = illegal_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed stimulus for alu_seq_unit (WIDTH=32) with a
// transaction-level reference model compared against the DUT every cycle,
// plus literal expected values for the documented examples.
module tb_alu_seq_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    aluop = '0;
  logic [5:0]    funct = '0;
  logic [4:0]    shamt = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, done, zero, illegal;
  logic [W-1:0]  result, hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .aluop   (aluop),
    .funct   (funct),
    .shamt   (shamt),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_result = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_done = 1'b0, m_ill = 1'b0, m_zero = 1'b1;
  int           m_busy = 0;

  task automatic model_accept();
    logic [W-1:0] r;
    logic [63:0]  p;
    longint       sa, sb;
    bit           multi, ill;
    r = '0; p = '0; multi = 0; ill = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (aluop == 2'b00)      r = a + b;
    else if (aluop == 2'b01) r = a - b;
    else begin
      case (funct)
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h00: r = b << shamt;
        6'h02: r = b >> shamt;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h18: begin multi = 1; p = 64'(sa * sb); p_hi = p[63:32]; p_lo = p[31:0]; end
        6'h19: begin multi = 1; p = {32'd0, a} * {32'd0, b}; p_hi = p[63:32]; p_lo = p[31:0]; end
        6'h1a: begin
          multi = 1;
          if (b == 0) begin p_lo = '1; p_hi = a; end
          else begin p = 64'(sa / sb); p_lo = p[31:0]; p = 64'(sa % sb); p_hi = p[31:0]; end
        end
        6'h1b: begin
          multi = 1;
          if (b == 0) begin p_lo = '1; p_hi = a; end
          else begin p_lo = a / b; p_hi = a % b; end
        end
        default: begin ill = 1; r = '0; end
      endcase
    end
    if (multi) m_busy = W + 1;
    else begin
      m_result = r; m_zero = (r == 0); m_done = 1; m_ill = ill;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_ill = 0; m_result = '0; m_zero = 1; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 0; m_ill = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_result = p_lo; m_zero = (p_lo == 0); m_done = 1;
        end
      end else if (start) begin
        model_accept();
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",   ready,   (m_busy == 0));
    chk("done",    done,    m_done);
    chk("illegal", illegal, m_ill);
    chk("result",  result,  m_result);
    chk("zero",    zero,    m_zero);
    chk("hi",      hi,      m_hi);
    chk("lo",      lo,      m_lo);
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [W-1:0] va, input logic [W-1:0] vb);
    aluop = op; funct = fn; shamt = sh; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle count from start (cycle 0) to the cycle done is visible
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  int           lat, ndone;
  logic [W-1:0] save_hi, save_lo;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  ready,   1);
    chk("rst_done",   done,    0);
    chk("rst_ill",    illegal, 0);
    chk("rst_result", result,  0);
    chk("rst_zero",   zero,    1);
    chk("rst_hi",     hi,      0);
    chk("rst_lo",     lo,      0);

    // start accepted on the first edge after release
    reset_n = 1'b1;
    issue(2'b10, 6'h20, 0, 32'd5, 32'd7);
    chk("add_done",   done,   1);
    chk("add_result", result, 32'h0000000C);
    chk("add_zero",   zero,   0);
    chk("add_ready",  ready,  1);

    issue(2'b01, 6'h00, 0, 32'd9, 32'd9);
    chk("sub_result", result, 0);
    chk("sub_zero",   zero,   1);
    issue(2'b10, 6'h2a, 0, 32'hFFFFFFFF, 32'd1);
    chk("slt_result", result, 1);
    issue(2'b10, 6'h24, 0, 32'h0000F0F0, 32'h0000FF00);
    chk("and_result", result, 32'h0000F000);
    issue(2'b10, 6'h27, 0, 32'd0, 32'd0);
    chk("nor_result", result, 32'hFFFFFFFF);
    issue(2'b10, 6'h00, 5'd4, 32'h12345678, 32'h000000F0);
    chk("sll_result", result, 32'h00000F00);
    issue(2'b10, 6'h02, 5'd31, 32'h0, 32'h80000000);
    chk("srl_result", result, 1);
    issue(2'b10, 6'h25, 0, 32'hA0A0A0A0, 32'h05050505);
    issue(2'b10, 6'h26, 0, 32'hFFFF0000, 32'h0F0F0F0F);
    issue(2'b00, 6'h3f, 0, 32'hFFFFFFFF, 32'd1);
    issue(2'b10, 6'h2a, 0, 32'd3, 32'h80000000);

    // signed multiply, then mflo/mfhi straight after done
    issue(2'b10, 6'h18, 0, 32'hFFFFFFFD, 32'd7);
    chk("mul_busy", ready, 0);
    wait_done(lat);
    chk("mul_latency", lat, 34);
    chk("mul_hi", hi, 32'hFFFFFFFF);
    chk("mul_lo", lo, 32'hFFFFFFEB);
    chk("mul_result", result, 32'hFFFFFFEB);
    issue(2'b10, 6'h12, 0, 32'd0, 32'd0);
    chk("mflo_result", result, 32'hFFFFFFEB);
    issue(2'b10, 6'h10, 0, 32'd0, 32'd0);
    chk("mfhi_result", result, 32'hFFFFFFFF);

    issue(2'b10, 6'h1b, 0, 32'd100, 32'd7);
    wait_done(lat);
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);
    issue(2'b10, 6'h1a, 0, 32'hFFFFFFF9, 32'd2);
    wait_done(lat);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(2'b10, 6'h1a, 0, 32'h00001234, 32'd0);
    wait_done(lat);
    chk("div0_latency", lat, 34);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'h00001234);
    issue(2'b10, 6'h1a, 0, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 0);
    issue(2'b10, 6'h19, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    issue(2'b10, 6'h1a, 0, 32'd7, 32'hFFFFFFFE);
    wait_done(lat);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 1);
    issue(2'b10, 6'h1a, 0, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait_done(lat);
    issue(2'b10, 6'h18, 0, 32'hFFFFFFFB, 32'hFFFFFFFD);
    wait_done(lat);
    issue(2'b10, 6'h1b, 0, 32'hFFFFFFFF, 32'h00010000);
    wait_done(lat);

    // undefined funct: done+illegal, result 0, hi/lo untouched
    save_hi = hi; save_lo = lo;
    issue(2'b10, 6'h3f, 0, 32'd1, 32'd2);
    chk("ill_done",   done,    1);
    chk("ill_flag",   illegal, 1);
    chk("ill_result", result,  0);
    chk("ill_hi",     hi,      save_hi);
    chk("ill_lo",     lo,      save_lo);

    // start held through a divide yields a single done
    aluop = 2'b10; funct = 6'h1b; a = 32'd1000; b = 32'd3; start = 1'b1;
    ndone = 0; lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin ndone++; start = 1'b0; break; end
    end
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("held_start_dones", ndone, 1);

    // reset during a divide aborts it
    issue(2'b10, 6'h1b, 0, 32'd5000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_ready2", ready, 1);
    chk("abort_hi2", hi, 0);
    chk("abort_lo2", lo, 0);

    issue(2'b00, 6'h00, 0, 32'hFFFFFFFF, 32'd1);
    chk("post_rst_add", result, 0);
    chk("post_rst_zero", zero, 1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal values 8..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request strobe; accepted only when ready=1.
REQ-006 aluop  input  2  00=add, 01=sub, 1x=decode funct.
REQ-007 funct  input  6  R-type function code.
REQ-008 shamt  input  SHW  shift amount for sll/srl.
REQ-009 a  input  WIDTH  operand A (rs).
REQ-010 b  input  WIDTH  operand B (rt/imm).
REQ-011 ready  output  1  unit idle, can accept start.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 result  output  WIDTH  registered result, held until next done.
REQ-014 zero  output  1  result==0, registered with result.
REQ-015 illegal  output  1  one-cycle pulse with done for an undefined funct.
REQ-016 hi, lo  output  WIDTH each  HI/LO registers.

Function
REQ-017 The operation set SHALL be:
- aluop 00/01: add/sub.
- funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor.
- funct 101010 slt signed.
- funct 000000 sll by shamt, 000010 srl by shamt.
- funct 010000 mfhi, 010010 mflo.
- funct 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH with no overflow flag; slt result SHALL be 1 or 0, zero-extended.
REQ-019 Single-cycle ops SHALL load result/zero and pulse done exactly 1 cycle after start is accepted; ready SHALL stay 1.
REQ-020 The FSM SHALL have states IDLE, MUL, DIV and FIX.
REQ-021 Multi-cycle start transitions: IDLE->MUL (mult/multu) or IDLE->DIV (div/divu).
REQ-022 MUL/DIV SHALL perform WIDTH iterations: shift-add multiply, restoring divide, both on operand magnitudes.
REQ-023 After the last iteration the FSM SHALL go MUL/DIV->FIX, then FIX->IDLE.
REQ-024 FIX SHALL apply sign correction for signed ops.
REQ-025 Multi-cycle latency SHALL be WIDTH+2 cycles from start to done.
REQ-026 During MUL/DIV/FIX, ready SHALL be 0 and start SHALL be ignored.
REQ-027 mult/multu SHALL write the 2*WIDTH product as hi=upper half, lo=lower half.
REQ-028 div/divu SHALL write lo=quotient and hi=remainder, truncating toward zero; the remainder takes the sign of the dividend.
REQ-029 Divide by zero SHALL keep the normal latency and give lo=all ones, hi=a.
REQ-030 Signed div of most-negative by -1 SHALL give lo=a, hi=0.
REQ-031 For mult/div, result SHALL equal the new lo value at done.
REQ-032 mfhi/mflo issued the cycle after a multi-cycle done SHALL return the updated hi/lo values.
REQ-033 An undefined funct SHALL pulse done and illegal together after 1 cycle, with result=0; hi/lo SHALL be unchanged.
REQ-034 A start in the same cycle as the FIX->IDLE transition SHALL be ignored, because ready=0 in that cycle.

Reset
REQ-035 While reset_n=0 the unit SHALL be held at: state IDLE, ready=1, done=0, illegal=0, result=0, zero=1, hi=0, lo=0, all iteration registers 0.
REQ-036 Reset asserted mid-operation SHALL abort the operation with no done pulse and SHALL clear hi/lo.
REQ-037 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-038 Shared package alu_pkg SHALL hold the aluop codes, funct codes, the 4-bit internal op encoding and the FSM state enum.
REQ-039 Combinational decode SHALL live in sub-module alu_op_decode (aluop/funct -> op code + multi-cycle flag + illegal flag); the FSM and datapath SHALL live in alu_seq_unit.

Verification (WIDTH=32)
REQ-040 aluop=10, funct=100000, a=5, b=7, start -> done next cycle, result=0x0000000C, zero=0.
REQ-041 aluop=01, a=b=9 -> result=0, zero=1; funct=101010, a=0xFFFFFFFF, b=1 -> result=1.
REQ-042 mult a=0xFFFFFFFD, b=7 -> done 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB; then mflo -> result=0xFFFFFFEB.
REQ-043 divu a=100, b=7 -> lo=14, hi=2; div a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-044 div a=0x1234, b=0 -> done after 34 cycles, lo=0xFFFFFFFF, hi=0x1234.
REQ-045 start held high during a divide -> exactly one done pulse.
REQ-045a reset_n pulsed low at cycle 10 of a divide -> no done pulse, hi=lo=0, ready=1.
REQ-045b funct=111111 -> done and illegal pulse together, result=0.
